// File: rtl/goldschmidt_pkg.sv
// Shared definitions for the Goldschmidt divider: FSM state type,
// iteration-counter sizing and the quotient fill used on divide-by-zero.
package goldschmidt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } gs_state_e;

    // Every quotient bit is set when the divisor is zero or unnormalised.
    localparam logic GS_DZ_FILL = 1'b1;

    // Counter width able to hold 0 .. iters-1 (at least one bit).
    function automatic int gs_cnt_w(input int iters);
        return (iters <= 2) ? 1 : $clog2(iters);
    endfunction

endpackage

// File: rtl/gs_iter_step.sv
// One combinational Goldschmidt convergence step.
// x and y are 1.(IW-1) fixed point. f = 2 - y is the IW-bit two's complement
// of y. Each 2.(2IW-2) product is cut back to 1.(IW-1) by truncation.
module gs_iter_step #(
    parameter int W  = 32,
    localparam int IW = 2 * W
) (
    input  logic [IW-1:0] x_i,
    input  logic [IW-1:0] y_i,
    output logic [IW-1:0] x_o,
    output logic [IW-1:0] y_o
);

    logic [IW-1:0]   f;
    logic [2*IW-1:0] px;
    logic [2*IW-1:0] py;

    // Scale both operands by the same factor; y heads toward 1.0.
    always_comb begin
        f   = (~y_i) + IW'(1);
        px  = {{IW{1'b0}}, x_i} * {{IW{1'b0}}, f};
        py  = {{IW{1'b0}}, y_i} * {{IW{1'b0}}, f};
        x_o = px[2*IW-2:IW-1];
        y_o = py[2*IW-2:IW-1];
    end

endmodule

// File: rtl/goldschmidt_div_param.sv
// Multi-cycle Goldschmidt divider for normalised .1xxx mantissas.
// q = a / b in x.xxx format after ITERS convergence steps.
// Optional rounding of the final quotient: define GS_DIV_ROUND_EN.
module goldschmidt_div_param
    import goldschmidt_pkg::*;
#(
    parameter int W     = 32,
    parameter int ITERS = 5
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         ready,
    output logic         dz
);

    localparam int            IW       = 2 * W;
    localparam int            CW       = gs_cnt_w(ITERS);
    localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

    gs_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] x_q, x_d;
    logic [IW-1:0] y_q, y_d;
    logic [W-1:0]  q_q, q_d;
    logic          ready_q, ready_d;
    logic          dz_q, dz_d;

    logic [IW-1:0] x_nx;
    logic [IW-1:0] y_nx;
    logic [W-1:0]  q_fin;

    gs_iter_step #(.W(W)) u_step (
        .x_i (x_q),
        .y_i (y_q),
        .x_o (x_nx),
        .y_o (y_nx)
    );

`ifdef GS_DIV_ROUND_EN
    logic [W:0] q_sum;
    // Round half up on the first dropped bit; saturate instead of wrapping.
    always_comb begin
        q_sum = {1'b0, x_nx[IW-1:IW-W]} + {{W{1'b0}}, x_nx[IW-W-1]};
        q_fin = q_sum[W] ? {W{GS_DZ_FILL}} : q_sum[W-1:0];
    end
`else
    // Plain truncation to 1 integer bit and W-1 fraction bits.
    always_comb begin
        q_fin = x_nx[IW-1:IW-W];
    end
`endif

    // Next-state and datapath control; start is only honoured outside ITER.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        q_d     = q_q;
        ready_d = ready_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (b[W-1]) begin
                        x_d     = {1'b0, a, {(W-1){1'b0}}};
                        y_d     = {1'b0, b, {(W-1){1'b0}}};
                        cnt_d   = '0;
                        ready_d = 1'b0;
                        dz_d    = 1'b0;
                        state_d = ITER;
                    end else begin
                        q_d     = {W{GS_DZ_FILL}};
                        ready_d = 1'b1;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ITER: begin
                x_d   = x_nx;
                y_d   = y_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    q_d     = q_fin;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            q_q     <= '0;
            ready_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            q_q     <= q_d;
            ready_q <= ready_d;
            dz_q    <= dz_d;
        end
    end

    assign q     = q_q;
    assign busy  = (state_q == ITER);
    assign ready = ready_q;
    assign dz    = dz_q;

endmodule

// File: tb/tb_goldschmidt_div_param.sv
// Bench for goldschmidt_div_param: a W=32/ITERS=5 instance and a
// W=16/ITERS=4 instance, checked against exact integer division.
module tb_goldschmidt_div_param;

    localparam int ITERS_A = 5;
    localparam int ITERS_B = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start, start16;
    logic [31:0] a, b, q;
    logic [15:0] a16, b16, q16;
    logic        busy, ready, dz;
    logic        busy16, ready16, dz16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    goldschmidt_div_param #(.W(32), .ITERS(ITERS_A)) dut (
        .clk(clk), .clrn(clrn), .start(start), .a(a), .b(b),
        .q(q), .busy(busy), .ready(ready), .dz(dz)
    );

    goldschmidt_div_param #(.W(16), .ITERS(ITERS_B)) dut16 (
        .clk(clk), .clrn(clrn), .start(start16), .a(a16), .b(b16),
        .q(q16), .busy(busy16), .ready(ready16), .dz(dz16)
    );

    // Exact truncated quotient in x.xxx format: floor(a * 2^(w-1) / b).
    function automatic longint ref_q(input int w, input logic [31:0] ai, input logic [31:0] bi);
        longint unsigned num;
        num = 64'(ai) << (w - 1);
        return longint'(num / 64'(bi));
    endfunction

    // Convergence leaves the quotient at most one LSB from the exact value.
    function automatic bit close_enough(input longint exp_q, input logic [31:0] got);
        longint d;
        d = exp_q - longint'(got);
        return (d >= -1) && (d <= 1);
    endfunction

    // Issue one operation starting at a negedge; returns at the negedge where
    // ready is first seen. lat counts edges after the accepting edge; bc counts
    // busy samples, plus one if busy is still up when ready rises.
    task automatic run_op(input bit sel, input logic [31:0] ai, input logic [31:0] bi,
                          output logic [31:0] qo, output bit dzo, output int lat,
                          output int bc, output bit to);
        if (sel) begin start16 = 1'b1; a16 = ai[15:0]; b16 = bi[15:0]; end
        else     begin start   = 1'b1; a   = ai;       b   = bi;       end
        @(negedge clk);
        start = 1'b0; start16 = 1'b0;
        a = $urandom; b = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0; bc = 0; to = 1'b0;
        while (!(sel ? ready16 : ready)) begin
            if (sel ? busy16 : busy) bc++;
            lat++;
            if (lat > 40) begin to = 1'b1; break; end
            @(negedge clk);
        end
        if (sel ? busy16 : busy) bc++;
        qo  = sel ? {16'h0, q16} : q;
        dzo = sel ? dz16 : dz;
    endtask

    task automatic test_reset;
        clrn = 1'b0; start = 1'b0; start16 = 1'b0;
        a = '0; b = '0; a16 = '0; b16 = '0;
        #1;
        checks++;
        if ({q, busy, ready, dz} !== 35'h0) begin
            errors++;
            $display("FAIL reset32: got q=%h busy=%b ready=%b dz=%b, need all 0", q, busy, ready, dz);
        end
        checks++;
        if ({q16, busy16, ready16, dz16} !== 19'h0) begin
            errors++;
            $display("FAIL reset16: got q=%h busy=%b ready=%b dz=%b, need all 0", q16, busy16, ready16, dz16);
        end
        @(negedge clk); @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] opa [2] = '{32'h8000_0000, 32'hC000_0000};
        logic [31:0] qo;
        bit dzo, to;
        int lat, bc;
        longint e;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b0, opa[i], 32'h8000_0000, qo, dzo, lat, bc, to);
            e = ref_q(32, opa[i], 32'h8000_0000);
            checks++;
            if (to || lat != ITERS_A || bc != ITERS_A) begin
                errors++;
                $display("FAIL directed_timing[%0d]: got lat=%0d busy_cycles=%0d timeout=%b, need %0d/%0d/0",
                         i, lat, bc, to, ITERS_A, ITERS_A);
            end
            checks++;
            if (!close_enough(e, qo) || dzo !== 1'b0) begin
                errors++;
                $display("FAIL directed_q[%0d]: got q=%h dz=%b, need q=%h+-1 dz=0", i, qo, dzo, e);
            end
        end
    endtask

    task automatic test_dz;
        logic [31:0] bz [2] = '{32'h0000_0000, 32'h7FFF_FFFF};
        logic [31:0] qo;
        bit dzo, to;
        int lat, bc;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b0, $urandom | 32'h8000_0000, bz[i], qo, dzo, lat, bc, to);
            checks++;
            if (to || lat != 0 || bc != 0 || qo !== 32'hFFFF_FFFF || dzo !== 1'b1) begin
                errors++;
                $display("FAIL dz[%0d]: got lat=%0d busy_cycles=%0d q=%h dz=%b, need 0/0/ffffffff/1",
                         i, lat, bc, qo, dzo);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({ready, dz, busy, q} !== {1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL dz_sticky: got ready=%b dz=%b busy=%b q=%h, need 1/1/0/ffffffff", ready, dz, busy, q);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        longint e;
        e = ref_q(32, 32'hC000_0000, 32'h8000_0000);
        start = 1'b1; a = 32'hC000_0000; b = 32'h8000_0000;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!ready && lat <= 40) begin
            // second ITER cycle: a start that would otherwise trigger dz
            start = (lat == 1);
            a = 32'h8000_0000; b = 32'h0;
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (lat != ITERS_A || !close_enough(e, q) || dz !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: got lat=%0d q=%h dz=%b, need lat=%0d q=%h+-1 dz=0",
                     lat, q, dz, ITERS_A, e);
        end
    endtask

    task automatic test_reset_mid_iter;
        logic [31:0] qo;
        bit dzo, to;
        int lat, bc;
        longint e;
        start = 1'b1; a = 32'h9000_0000; b = 32'hA000_0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        clrn = 1'b0;
        #1;
        checks++;
        if ({q, busy, ready, dz} !== 35'h0) begin
            errors++;
            $display("FAIL reset_mid_iter: got q=%h busy=%b ready=%b dz=%b, need all 0", q, busy, ready, dz);
        end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'h8000_0000, 32'hC000_0000, qo, dzo, lat, bc, to);
        e = ref_q(32, 32'h8000_0000, 32'hC000_0000);
        checks++;
        if (to || lat != ITERS_A || !close_enough(e, qo) || dzo !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d q=%h dz=%b, need lat=%0d q=%h+-1 dz=0",
                     lat, qo, dzo, ITERS_A, e);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] qo, ai, bi;
        bit dzo, to;
        int lat, bc;
        longint e;
        // each op starts in the same cycle the previous one shows ready
        for (int i = 0; i < 4; i++) begin
            ai = $urandom | 32'h8000_0000;
            bi = $urandom | 32'h8000_0000;
            run_op(1'b0, ai, bi, qo, dzo, lat, bc, to);
            e = ref_q(32, ai, bi);
            checks++;
            if (to || lat != ITERS_A || bc != ITERS_A || !close_enough(e, qo) || dzo !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got lat=%0d busy_cycles=%0d q=%h dz=%b, need %0d/%0d q=%h+-1 dz=0",
                         i, lat, bc, qo, dzo, ITERS_A, ITERS_A, e);
            end
        end
    endtask

    task automatic test_random(input bit sel, input int n);
        int w, it;
        logic [31:0] ai, bi, qo, msb, mask;
        bit dzo, to, unnorm;
        int lat, bc;
        longint e;
        w    = sel ? 16 : 32;
        it   = sel ? ITERS_B : ITERS_A;
        msb  = sel ? 32'h0000_8000 : 32'h8000_0000;
        mask = sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            unnorm = ($urandom_range(0, 15) == 0);
            ai = ($urandom & mask) | msb;
            bi = unnorm ? ($urandom & mask & ~msb) : (($urandom & mask) | msb);
            run_op(sel, ai, bi, qo, dzo, lat, bc, to);
            checks++;
            if (unnorm) begin
                if (to || lat != 0 || qo !== mask || dzo !== 1'b1) begin
                    errors++;
                    $display("FAIL random_dz w=%0d a=%h b=%h: got lat=%0d q=%h dz=%b, need 0/%h/1",
                             w, ai, bi, lat, qo, dzo, mask);
                end
            end else begin
                e = ref_q(w, ai, bi);
                if (to || lat != it || bc != it || !close_enough(e, qo) || dzo !== 1'b0) begin
                    errors++;
                    $display("FAIL random w=%0d a=%h b=%h: got lat=%0d busy_cycles=%0d q=%h dz=%b, need %0d/%0d q=%h+-1 dz=0",
                             w, ai, bi, lat, bc, qo, dzo, it, it, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_dz();
        test_start_ignored();
        test_reset_mid_iter();
        test_back_to_back();
        test_random(1'b0, 5000);
        test_random(1'b1, 1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
